// File: rtl/dw_lp_cntr_seq_ctrl.sv
// Load/count/repeat sequencer for dw_lp_cntr_up_df.
// Drives the counter's load, terminal value and enable; reports busy/done.
module dw_lp_cntr_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int RPT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] cfg_start_val,
   input  logic [WIDTH-1:0] cfg_term_val,
   input  logic [RPT_W-1:0] cfg_repeat,
   input  logic             cnt_term_count_n,
   output logic             cnt_ld_n,
   output logic [WIDTH-1:0] cnt_ld_count,
   output logic [WIDTH-1:0] cnt_term_val,
   output logic             cnt_enable,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [RPT_W-1:0] run_idx
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      COUNT = 3'd2,
      DONE  = 3'd3,
      ABORT = 3'd4
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] start_q;
   logic [WIDTH-1:0] term_q;
   logic [RPT_W-1:0] rpt_q;
   logic [RPT_W-1:0] idx_q;
   logic [RPT_W-1:0] idx_inc;
   logic [RPT_W:0]   idx_p1;
   logic             accept;
   logic             at_term;
   logic             last_run;

   assign accept   = (state_q == IDLE) && start && !abort;
   assign at_term  = (state_q == COUNT) && !cnt_term_count_n && !abort;
   assign idx_p1   = {1'b0, idx_q} + {{RPT_W{1'b0}}, 1'b1};
   assign last_run = !(idx_p1 < {1'b0, rpt_q});
   // Saturate so a full-scale repeat count never wraps the index.
   assign idx_inc  = (idx_q == {RPT_W{1'b1}}) ? idx_q : idx_p1[RPT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= '0;
         term_q  <= '0;
         rpt_q   <= '0;
         idx_q   <= '0;
      end else if (accept) begin
         start_q <= cfg_start_val;
         term_q  <= cfg_term_val;
         rpt_q   <= (cfg_repeat == '0) ? {{(RPT_W-1){1'b0}}, 1'b1}
                                       : cfg_repeat;
         idx_q   <= '0;
      end else if (at_term) begin
         idx_q   <= idx_inc;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = LOAD;
         end
         LOAD: begin
            state_d = abort ? ABORT : COUNT;
         end
         COUNT: begin
            if (abort) begin
               state_d = ABORT;
            end else if (!cnt_term_count_n) begin
               state_d = last_run ? DONE : LOAD;
            end
         end
         DONE: begin
            state_d = abort ? ABORT : IDLE;
         end
         ABORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Enable is gated by the live flag so the counter stops on terminal.
   assign cnt_enable   = (state_q == COUNT) && cnt_term_count_n && !abort;
   assign cnt_ld_n     = (state_q != LOAD);
   assign cnt_ld_count = start_q;
   assign cnt_term_val = term_q;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign aborted      = (state_q == ABORT);
   assign run_idx      = idx_q;

endmodule
